// File: rtl/logicgate_checker_if.sv
// Stimulus/response bundle between the gate-bank checker and its driver.
// The slave side is the checker; the master side owns start and gate_in.
interface logicgate_checker_if;
    logic       start;
    logic [6:0] gate_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] fail_mask;

    modport master (
        output start, gate_in,
        input  a_out, b_out, busy, done, pass, fail_mask
    );

    modport slave (
        input  start, gate_in,
        output a_out, b_out, busy, done, pass, fail_mask
    );
endinterface

// File: rtl/logicgate_checker.sv
// Self-test sweep for a two-input gate bank: drives all four (a,b) vectors,
// waits SETTLE_CYCLES per vector, and accumulates a sticky per-gate fail mask.
module logicgate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    logicgate_checker_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    // With no settle time a freshly driven vector is sampled on the very next edge.
    localparam state_e AFTER_DRIVE = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [6:0]       fail_mask_q, fail_mask_d;

    // Bit order {xnor,xor,nor,nand,not,or,and}.
    function automatic logic [6:0] expected(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    fail_mask_d = '0;
                    pass_d      = 1'b0;
                    idx_d       = 2'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    cnt_d       = '0;
                    state_d     = AFTER_DRIVE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                fail_mask_d = fail_mask_q | (bus.gate_in ^ expected(a_q, b_q));
                if (idx_q == 2'd3) begin
                    pass_d  = (fail_mask_d == '0);
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    cnt_d   = '0;
                    state_d = AFTER_DRIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_logicgate_checker.sv
// Bench for logicgate_checker: two instances (settle 2 and settle 0) against a
// sweep-position model, a faultable gate bank, directed scenarios and random starts.
module tb_logicgate_checker;

    localparam int S0 = 2;
    localparam int S1 = 0;
    // Hand-written truth table of the gate bank, index {a,b}, bits {xnor,xor,nor,nand,not,or,and}.
    localparam logic [6:0] GOLD [4] = '{7'b1011100, 7'b0101110, 7'b0101010, 7'b1000011};

    logic       clk;
    logic       rst_n;
    logic       start_s  [2];
    logic [6:0] gate_w   [2];
    logic       a_w      [2];
    logic       b_w      [2];
    logic       busy_w   [2];
    logic       done_w   [2];
    logic       pass_w   [2];
    logic [6:0] mask_w   [2];

    logic [6:0] tbl       [2][4];   // per-vector corruption applied at sample time
    logic [6:0] junk      [2];      // garbage shown outside sample cycles
    int         k         [2];      // model: 0 idle, else cycle number within the sweep
    logic [6:0] hold_mask [2];
    logic       hold_pass [2];
    int         done_seen [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logicgate_checker_if bus ();
        logicgate_checker #(.SETTLE_CYCLES(g == 0 ? S0 : S1), .CNT_W(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.start   = start_s[g];
        assign bus.gate_in = gate_w[g];
        assign a_w[g]      = bus.a_out;
        assign b_w[g]      = bus.b_out;
        assign busy_w[g]   = bus.busy;
        assign done_w[g]   = bus.done;
        assign pass_w[g]   = bus.pass;
        assign mask_w[g]   = bus.fail_mask;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int per_of(input int d);
        return (d == 0) ? S0 + 1 : S1 + 1;
    endfunction

    function automatic int len_of(input int d);
        return 4 * per_of(d) + 1;
    endfunction

    // Mask visible in sweep cycle kk: vector v is sampled at the end of cycle (v+1)*per.
    function automatic logic [6:0] mask_at(input int d, input int kk);
        logic [6:0] m = '0;
        for (int v = 0; v < 4; v++)
            if ((v + 1) * per_of(d) + 1 <= kk) m |= tbl[d][v];
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gate bank: correct, except for the injected fault on sample cycles and junk elsewhere.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            logic in_sample;
            in_sample = (k[d] >= 1) && (k[d] <= 4 * per_of(d)) && (k[d] % per_of(d) == 0);
            gate_w[d] = GOLD[{a_w[d], b_w[d]}] ^ (in_sample ? tbl[d][{a_w[d], b_w[d]}] : junk[d]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                k[d]         <= 0;
                hold_mask[d] <= '0;
                hold_pass[d] <= 1'b0;
                junk[d]      <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                junk[d] <= 7'($urandom);
                if (k[d] == 0) begin
                    if (start_s[d]) k[d] <= 1;
                end else if (k[d] == len_of(d)) begin
                    k[d]         <= 0;
                    hold_mask[d] <= mask_at(d, len_of(d));
                    hold_pass[d] <= (mask_at(d, len_of(d)) == '0);
                end else begin
                    k[d] <= k[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                logic ea, eb, ebusy, edone, epass;
                logic [6:0] emask;
                int v;
                ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
                emask = hold_mask[d]; epass = hold_pass[d];
                if (k[d] != 0) begin
                    ebusy = 1'b1;
                    emask = mask_at(d, k[d]);
                    edone = (k[d] == len_of(d));
                    epass = edone && (emask == '0);
                    if (k[d] <= 4 * per_of(d)) begin
                        v  = (k[d] - 1) / per_of(d);
                        ea = (v >= 2);
                        eb = (v % 2 == 1);
                    end
                end
                if (done_w[d]) done_seen[d]++;
                check($sformatf("d%0d a_out", d), 32'(a_w[d]), 32'(ea));
                check($sformatf("d%0d b_out", d), 32'(b_w[d]), 32'(eb));
                check($sformatf("d%0d busy", d), 32'(busy_w[d]), 32'(ebusy));
                check($sformatf("d%0d done", d), 32'(done_w[d]), 32'(edone));
                check($sformatf("d%0d pass", d), 32'(pass_w[d]), 32'(epass));
                check($sformatf("d%0d fail_mask", d), 32'(mask_w[d]), 32'(emask));
            end
        end
    end

    task automatic set_tbl(input int d, input logic [6:0] t0, input logic [6:0] t1,
                           input logic [6:0] t2, input logic [6:0] t3);
        tbl[d][0] = t0; tbl[d][1] = t1; tbl[d][2] = t2; tbl[d][3] = t3;
    endtask

    task automatic wait_idle();
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    // One sweep on instance d; returns the cycle done was seen and the (a,b) pairs at each sample.
    task automatic sweep(input int d, input int repulse, output int dn, output logic [7:0] seq);
        int n;
        seq = '0;
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        n = 1;
        while (n < 60) begin
            if (n % per_of(d) == 0 && n <= 4 * per_of(d)) seq = {seq[5:0], a_w[d], b_w[d]};
            if (done_w[d]) break;
            start_s[d] = (n == repulse);
            @(negedge clk);
            n++;
        end
        start_s[d] = 1'b0;
        dn = n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, ds;
        logic [7:0] seq;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        for (int d = 0; d < 2; d++) set_tbl(d, '0, '0, '0, '0);
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset a_out", 32'(a_w[d]), 0);
            check("reset busy", 32'(busy_w[d]), 0);
            check("reset done", 32'(done_w[d]), 0);
            check("reset pass", 32'(pass_w[d]), 0);
            check("reset fail_mask", 32'(mask_w[d]), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Golden bank, settle 2: done in cycle 13, clean result, busy drops after.
        sweep(0, -1, dn, seq);
        check("s1 done cycle", 32'(dn), 13);
        check("s1 pass", 32'(pass_w[0]), 1);
        check("s1 fail_mask", 32'(mask_w[0]), 0);
        @(negedge clk);
        check("s1 busy after done", 32'(busy_w[0]), 0);
        wait_idle();

        // xor stuck at 0: only vectors (0,1),(1,0) disagree.
        set_tbl(0, '0, 7'b0100000, 7'b0100000, '0);
        sweep(0, -1, dn, seq);
        check("s2 vector order", 32'(seq), 32'h1b);
        check("s2 fail_mask", 32'(mask_w[0]), 32'h20);
        check("s2 pass", 32'(pass_w[0]), 0);
        wait_idle();

        // not wired as ~b: differs from ~a exactly when a!=b.
        set_tbl(0, '0, 7'b0000100, 7'b0000100, '0);
        sweep(0, -1, dn, seq);
        check("s3 fail_mask", 32'(mask_w[0]), 32'h04);
        check("s3 pass", 32'(pass_w[0]), 0);
        wait_idle();

        // start re-pulsed during settle of vector 1 is ignored.
        set_tbl(0, '0, '0, '0, '0);
        ds = done_seen[0];
        sweep(0, 4, dn, seq);
        check("s4 done cycle", 32'(dn), 13);
        wait_idle();
        check("s4 single done", 32'(done_seen[0] - ds), 1);

        // Reset during vector 2 aborts with no done; a later sweep is clean.
        set_tbl(0, 7'b0000010, '0, '0, '0);
        ds = done_seen[0];
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("s5 mask before reset", 32'(mask_w[0]), 32'h02);
        check("s5 b_out before reset", 32'(b_w[0]), 0);
        check("s5 a_out before reset", 32'(a_w[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s5 a_out in reset", 32'(a_w[0]), 0);
        check("s5 busy in reset", 32'(busy_w[0]), 0);
        check("s5 fail_mask in reset", 32'(mask_w[0]), 0);
        check("s5 done in reset", 32'(done_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        check("s5 no done after abort", 32'(done_seen[0] - ds), 0);
        set_tbl(0, '0, '0, '0, '0);
        sweep(0, -1, dn, seq);
        check("s5 done cycle", 32'(dn), 13);
        check("s5 pass", 32'(pass_w[0]), 1);
        wait_idle();

        // Settle 0 with start held: back-to-back sweeps, mask cleared on the restart.
        set_tbl(1, '0, '0, '0, 7'b0000001);
        start_s[1] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 5)  check("s6 first done", 32'(done_w[1]), 1);
            if (n == 5)  check("s6 first fail_mask", 32'(mask_w[1]), 32'h01);
            if (n == 6)  check("s6 idle busy", 32'(busy_w[1]), 0);
            if (n == 6)  check("s6 idle mask held", 32'(mask_w[1]), 32'h01);
            if (n == 7)  check("s6 restart busy", 32'(busy_w[1]), 1);
            if (n == 7)  check("s6 restart mask cleared", 32'(mask_w[1]), 0);
            if (n == 10) check("s6 no early done", 32'(done_w[1]), 0);
            if (n == 11) check("s6 second done", 32'(done_w[1]), 1);
            if (n == 11) check("s6 second pass", 32'(pass_w[1]), 0);
        end
        wait_idle();

        // Random faults and random start traffic on both instances.
        repeat (25) begin
            for (int d = 0; d < 2; d++)
                for (int v = 0; v < 4; v++)
                    tbl[d][v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            repeat (40) begin
                @(negedge clk);
                start_s[0] = ($urandom_range(0, 3) == 0);
                start_s[1] = ($urandom_range(0, 3) == 0);
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
